// File: rtl/wb_sdram_arbiter_pkg.sv
// Shared constants for the two-master SDRAM Wishbone arbiter.
//   arb_state_t : arbiter FSM state encodings
//   ARB_MA/MB   : master IDs used for the grant history and the response mux
package wb_sdram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN_A = 2'd1,
    ARB_OWN_B = 2'd2,
    ARB_DRAIN = 2'd3
  } arb_state_t;

  localparam logic ARB_MA = 1'b0;
  localparam logic ARB_MB = 1'b1;

endpackage

// File: rtl/wb_sdram_arbiter_ctr.sv
// Outstanding-request counter for the SDRAM arbiter.
//   i_clk, i_rst : clock, async active-high reset
//   i_clr        : synchronous clear (abort, error)
//   i_inc        : a strobe was accepted by the slave
//   i_dec        : slave ack; ignored while the counter is empty
//   o_full       : count == 2^LGOUT-1, no further strobes may pass
//   o_empty      : nothing in flight
module wb_outstanding_ctr #(
  parameter int LGOUT = 5
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full,
  output logic o_empty
);

  logic [LGOUT-1:0] count;
  logic             dec_ok;

  // A stray ack with nothing in flight must not wrap the counter.
  assign dec_ok  = i_dec && !o_empty;
  assign o_full  = &count;
  assign o_empty = (count == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                 count <= '0;
    else if (i_clr)            count <= '0;
    else if (i_inc && !dec_ok) count <= count + 1'b1;
    else if (!i_inc && dec_ok) count <= count - 1'b1;
  end

endmodule

// File: rtl/wb_sdram_arbiter.sv
// Two-master pipelined Wishbone arbiter in front of the SDRAM slave.
// Master A (CPU data) and master B (DMA) share one slave; every response is
// returned to the master that currently owns the bus. Ownership only changes
// after the owner drops cyc, receives an error, or (with fairness) drains.
//
// Optional feature: define WBARB_FAIRNESS_EN to force a hand-off after
// MAXBURST accepted strobes while the other master is waiting.
//
// Ports:
//   i_clk, i_rst            : SDRAM system clock, async active-high reset
//   i_a_* / o_a_*           : master A request / response
//   i_b_* / o_b_*           : master B request / response
//   o_cyc..o_sel            : request to the SDRAM slave
//   i_ack, i_stall, i_err,
//   i_data                  : response from the SDRAM slave
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ARB_IDLE  | no owner, o_cyc low
// ARB_OWN_A | master A owns the slave
// ARB_OWN_B | master B owns the slave
// ARB_DRAIN | owner cut off, waiting for its outstanding acks
module wb_sdram_arbiter #(
  parameter int AW       = 26,
  parameter int DW       = 32,
  parameter int LGOUT    = 5,
  parameter int MAXBURST = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_a_cyc,
  input  logic            i_a_stb,
  input  logic            i_a_we,
  input  logic [AW-1:0]   i_a_addr,
  input  logic [DW-1:0]   i_a_data,
  input  logic [DW/8-1:0] i_a_sel,
  output logic            o_a_ack,
  output logic            o_a_stall,
  output logic            o_a_err,
  output logic [DW-1:0]   o_a_data,
  input  logic            i_b_cyc,
  input  logic            i_b_stb,
  input  logic            i_b_we,
  input  logic [AW-1:0]   i_b_addr,
  input  logic [DW-1:0]   i_b_data,
  input  logic [DW/8-1:0] i_b_sel,
  output logic            o_b_ack,
  output logic            o_b_stall,
  output logic            o_b_err,
  output logic [DW-1:0]   o_b_data,
  output logic            o_cyc,
  output logic            o_stb,
  output logic            o_we,
  output logic [AW-1:0]   o_addr,
  output logic [DW-1:0]   o_data,
  output logic [DW/8-1:0] o_sel,
  input  logic            i_ack,
  input  logic            i_stall,
  input  logic            i_err,
  input  logic [DW-1:0]   i_data
);

  import wb_sdram_arbiter_pkg::*;

  if (MAXBURST < 1) begin : g_bad_maxburst
    $error("MAXBURST must be at least 1");
  end

  arb_state_t state, state_nxt;
  logic       last, last_nxt;
  logic       owner, own, own_a, own_b, draining, cut;
  logic       m_cyc, m_stb, m_we;
  logic       full, empty, accept, ctr_clr, owner_stall;

  // In DRAIN the owner is the master granted last.
  assign own      = (state != ARB_IDLE);
  assign owner    = (state == ARB_OWN_A) ? ARB_MA :
                    (state == ARB_OWN_B) ? ARB_MB : last;
  assign own_a    = own && (owner == ARB_MA);
  assign own_b    = own && (owner == ARB_MB);
  assign draining = (state == ARB_DRAIN);

  assign m_cyc  = (owner == ARB_MB) ? i_b_cyc  : i_a_cyc;
  assign m_stb  = (owner == ARB_MB) ? i_b_stb  : i_a_stb;
  assign m_we   = (owner == ARB_MB) ? i_b_we   : i_a_we;
  assign o_addr = (owner == ARB_MB) ? i_b_addr : i_a_addr;
  assign o_data = (owner == ARB_MB) ? i_b_data : i_a_data;
  assign o_sel  = (owner == ARB_MB) ? i_b_sel  : i_a_sel;

  assign o_cyc       = own && m_cyc;
  assign o_stb       = o_cyc && m_stb && !full && !draining && !cut;
  assign o_we        = o_cyc && m_we;
  assign accept      = o_stb && !i_stall;
  assign owner_stall = i_stall || full || draining || cut;

  assign o_a_stall = !own_a || owner_stall;
  assign o_a_ack   = own_a && i_ack;
  assign o_a_err   = own_a && i_err;
  assign o_a_data  = own_a ? i_data : '0;
  assign o_b_stall = !own_b || owner_stall;
  assign o_b_ack   = own_b && i_ack;
  assign o_b_err   = own_b && i_err;
  assign o_b_data  = own_b ? i_data : '0;

`ifdef WBARB_FAIRNESS_EN
  localparam int BW = $clog2(MAXBURST + 1);
  logic [BW-1:0] burst_cnt;
  logic          other_cyc;

  assign other_cyc = (owner == ARB_MA) ? i_b_cyc : i_a_cyc;
  // Cut-off is combinational so the owner is stalled on the very cycle the
  // limit is hit; otherwise one extra strobe would slip through.
  assign cut = ((state == ARB_OWN_A) || (state == ARB_OWN_B)) &&
               (burst_cnt == BW'(MAXBURST)) && other_cyc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                   burst_cnt <= '0;
    else if (state == ARB_IDLE)                  burst_cnt <= '0;
    else if (accept && burst_cnt != BW'(MAXBURST)) burst_cnt <= burst_cnt + 1'b1;
  end
`else
  assign cut = 1'b0;
`endif

  wb_outstanding_ctr #(.LGOUT(LGOUT)) u_ctr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (ctr_clr),
    .i_inc   (accept),
    .i_dec   (i_ack),
    .o_full  (full),
    .o_empty (empty)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ARB_IDLE;
      last  <= ARB_MA;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    ctr_clr   = 1'b0;
    case (state)
      ARB_IDLE: begin
        // On a tie the master not granted last wins.
        if (i_a_cyc && (!i_b_cyc || last == ARB_MB)) begin
          state_nxt = ARB_OWN_A;
          last_nxt  = ARB_MA;
        end else if (i_b_cyc) begin
          state_nxt = ARB_OWN_B;
          last_nxt  = ARB_MB;
        end
      end
      ARB_OWN_A, ARB_OWN_B: begin
        // Dropping cyc is an abort: in-flight acks are forgotten.
        if (!m_cyc || i_err) begin
          state_nxt = ARB_IDLE;
          ctr_clr   = 1'b1;
        end else if (cut) begin
          state_nxt = ARB_DRAIN;
        end
      end
      ARB_DRAIN: begin
        // Only reachable with fairness compiled in.
        if (!m_cyc || i_err) begin
          state_nxt = ARB_IDLE;
          ctr_clr   = 1'b1;
        end else if (empty) begin
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
module tb_wb_sdram_arbiter;
  import wb_sdram_arbiter_pkg::*;

  localparam int AW = 26;
  localparam int DW = 32;
  localparam int LGOUT = 5;
  localparam int MAXBURST = 8;

  typedef struct { logic [DW-1:0] data; logic err; } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic a_cyc = 0, a_stb = 0, a_we = 0, b_cyc = 0, b_stb = 0, b_we = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic [DW/8-1:0] a_sel = '1, b_sel = '1;
  logic a_ack, a_stall, a_err, b_ack, b_stall, b_err;
  logic [DW-1:0] a_rdata, b_rdata;
  logic s_cyc, s_stb, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [DW/8-1:0] s_sel;
  logic s_ack = 0, s_stall = 0, s_err = 0;
  logic [DW-1:0] s_rdata = '0;

  logic ack_en = 1, err_en = 0;
  logic [AW-1:0] err_addr = '0;
  logic [AW-1:0] pend[$];
  exp_t sb_a[$], sb_b[$];
  int checks = 0, errors = 0;

  wb_sdram_arbiter #(.AW(AW), .DW(DW), .LGOUT(LGOUT), .MAXBURST(MAXBURST)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr),
    .i_a_data(a_wdata), .i_a_sel(a_sel),
    .o_a_ack(a_ack), .o_a_stall(a_stall), .o_a_err(a_err), .o_a_data(a_rdata),
    .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr),
    .i_b_data(b_wdata), .i_b_sel(b_sel),
    .o_b_ack(b_ack), .o_b_stall(b_stall), .o_b_err(b_err), .o_b_data(b_rdata),
    .o_cyc(s_cyc), .o_stb(s_stb), .o_we(s_we), .o_addr(s_addr), .o_data(s_wdata),
    .o_sel(s_sel), .i_ack(s_ack), .i_stall(s_stall), .i_err(s_err), .i_data(s_rdata)
  );

  always #5 clk = ~clk;

  // Registered slave model plus scoreboard push on each accepted master strobe.
  logic [AW-1:0] pa;
  exp_t pe;
  always @(posedge clk) begin
    s_ack <= 1'b0;
    s_err <= 1'b0;
    if (!rst) begin
      if (ack_en && pend.size() > 0) begin
        pa = pend.pop_front();
        s_rdata <= {{(DW-AW){1'b0}}, pa} + 32'h90;
        if (err_en && pa == err_addr) s_err <= 1'b1;
        else s_ack <= 1'b1;
      end
      if (s_stb && !s_stall) pend.push_back(s_addr);
      if (a_cyc && a_stb && !a_stall) begin
        pe.data = {{(DW-AW){1'b0}}, a_addr} + 32'h90;
        pe.err  = err_en && (a_addr == err_addr);
        sb_a.push_back(pe);
      end
      if (b_cyc && b_stb && !b_stall) begin
        pe.data = {{(DW-AW){1'b0}}, b_addr} + 32'h90;
        pe.err  = err_en && (b_addr == err_addr);
        sb_b.push_back(pe);
      end
    end
  end

  // Scoreboard pop: every response a master sees must match its next expectation.
  exp_t me;
  always @(negedge clk) begin
    #2;
    if (!rst && (a_ack || a_err)) begin
      checks++;
      if (sb_a.size() == 0) begin
        errors++;
        $display("FAIL a_resp: got ack=%0b err=%0b data=%h, required no response", a_ack, a_err, a_rdata);
      end else begin
        me = sb_a.pop_front();
        if (a_err !== me.err || (!me.err && a_rdata !== me.data)) begin
          errors++;
          $display("FAIL a_resp: got err=%0b data=%h, required err=%0b data=%h", a_err, a_rdata, me.err, me.data);
        end
      end
    end
    if (!rst && (b_ack || b_err)) begin
      checks++;
      if (sb_b.size() == 0) begin
        errors++;
        $display("FAIL b_resp: got ack=%0b err=%0b data=%h, required no response", b_ack, b_err, b_rdata);
      end else begin
        me = sb_b.pop_front();
        if (b_err !== me.err || (!me.err && b_rdata !== me.data)) begin
          errors++;
          $display("FAIL b_resp: got err=%0b data=%h, required err=%0b data=%h", b_err, b_rdata, me.err, me.data);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    a_cyc = 0; a_stb = 0; a_we = 0; b_cyc = 0; b_stb = 0; b_we = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({s_cyc, s_stb, s_we, a_ack, a_err, b_ack, b_err, a_stall, b_stall} !== 9'b000000011) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 000000011", {s_cyc, s_stb, s_we, a_ack, a_err, b_ack, b_err, a_stall, b_stall});
    end
    checks++;
    if (dut.state !== ARB_IDLE || dut.last !== ARB_MA || dut.u_ctr.count !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: got state=%0d last=%0b count=%0d, required 0 0 0", dut.state, dut.last, dut.u_ctr.count);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_a();
    int n = 0;
    @(negedge clk);
    a_cyc = 1; a_stb = 1; a_we = 0; a_addr = AW'(32'h10);
    #1;
    checks++;
    if (a_stall !== 1'b1 || s_cyc !== 1'b0) begin
      errors++;
      $display("FAIL single_pregrant: got stall=%b cyc=%b, required 1 0", a_stall, s_cyc);
    end
    for (int i = 0; i < 20 && n < 4; i++) begin
      @(negedge clk);
      a_addr = AW'(32'h10 + n);
      #1;
      if (i == 0) begin
        checks++;
        if (dut.state !== ARB_OWN_A || s_stb !== 1'b1 || a_stall !== 1'b0) begin
          errors++;
          $display("FAIL single_grant: got state=%0d stb=%b stall=%b, required 1 1 0", dut.state, s_stb, a_stall);
        end
      end
      checks++;
      if (b_stall !== 1'b1) begin errors++; $display("FAIL single_b_stall: got %b, required 1", b_stall); end
      if (!a_stall) n++;
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL single_count: got %0d strobes, required 4", n); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a_stb = 0;
      #1;
      checks++;
      if (b_stall !== 1'b1) begin errors++; $display("FAIL single_b_stall: got %b, required 1", b_stall); end
      if (sb_a.size() == 0) break;
    end
    checks++;
    if (sb_a.size() != 0 || dut.u_ctr.count !== 5'd0) begin
      errors++;
      $display("FAIL single_drain: got pending=%0d count=%0d, required 0 0", sb_a.size(), dut.u_ctr.count);
    end
    @(negedge clk);
    a_cyc = 0;
    @(negedge clk);
    #1;
    checks++;
    if (dut.state !== ARB_IDLE) begin errors++; $display("FAIL single_idle: got state=%0d, required 0", dut.state); end
  endtask

  task automatic test_tie();
    do_reset();
    @(negedge clk);
    a_cyc = 1; b_cyc = 1;
    #1;
    @(negedge clk);
    #1;
    checks++;
    if (dut.state !== ARB_OWN_B || a_stall !== 1'b1 || s_cyc !== 1'b1) begin
      errors++;
      $display("FAIL tie_grant: got state=%0d a_stall=%b cyc=%b, required 2 1 1", dut.state, a_stall, s_cyc);
    end
    b_stb = 1; b_addr = AW'(32'h200);
    @(negedge clk);
    b_stb = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (sb_b.size() == 0) break;
    end
    checks++;
    if (sb_b.size() != 0) begin errors++; $display("FAIL tie_b_read: got pending=%0d, required 0", sb_b.size()); end
    @(negedge clk);
    b_cyc = 0;
    #1;
    checks++;
    if (s_cyc !== 1'b0) begin errors++; $display("FAIL tie_drop: got cyc=%b, required 0", s_cyc); end
    @(negedge clk);
    #1;
    checks++;
    if (dut.state !== ARB_IDLE || s_cyc !== 1'b0) begin
      errors++;
      $display("FAIL tie_gap: got state=%0d cyc=%b, required 0 0", dut.state, s_cyc);
    end
    @(negedge clk);
    #1;
    checks++;
    if (dut.state !== ARB_OWN_A || s_cyc !== 1'b1) begin
      errors++;
      $display("FAIL tie_a_grant: got state=%0d cyc=%b, required 1 1", dut.state, s_cyc);
    end
    @(negedge clk);
    a_cyc = 0;
    @(negedge clk);
  endtask

  task automatic test_full();
    int n = 0;
    ack_en = 0;
    @(negedge clk);
    a_cyc = 1; a_stb = 1; a_we = 0;
    for (int i = 0; i < 40 && n < 31; i++) begin
      @(negedge clk);
      a_addr = AW'(32'h100 + n);
      #1;
      if (!a_stall) n++;
    end
    checks++;
    if (n != 31) begin errors++; $display("FAIL full_accepted: got %0d, required 31", n); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a_addr = AW'(32'h100 + 31);
      #1;
      checks++;
      if (a_stall !== 1'b1 || s_stb !== 1'b0 || dut.u_ctr.count !== 5'd31) begin
        errors++;
        $display("FAIL full_stall: got stall=%b stb=%b count=%0d, required 1 0 31", a_stall, s_stb, dut.u_ctr.count);
      end
    end
    ack_en = 1;
    @(negedge clk);
    #1;
    checks++;
    if (a_ack !== 1'b1 || a_stall !== 1'b1 || s_stb !== 1'b0) begin
      errors++;
      $display("FAIL full_first_ack: got ack=%b stall=%b stb=%b, required 1 1 0", a_ack, a_stall, s_stb);
    end
    @(negedge clk);
    #1;
    checks++;
    if (a_stall !== 1'b0 || s_stb !== 1'b1) begin
      errors++;
      $display("FAIL full_release: got stall=%b stb=%b, required 0 1", a_stall, s_stb);
    end
    @(negedge clk);
    a_stb = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (sb_a.size() == 0) break;
    end
    checks++;
    if (sb_a.size() != 0 || dut.u_ctr.count !== 5'd0) begin
      errors++;
      $display("FAIL full_drain: got pending=%0d count=%0d, required 0 0", sb_a.size(), dut.u_ctr.count);
    end
    a_cyc = 0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    int n = 0;
    ack_en = 0;
    @(negedge clk);
    a_cyc = 1; a_stb = 1;
    for (int i = 0; i < 10 && n < 3; i++) begin
      @(negedge clk);
      a_addr = AW'(32'h40 + n);
      #1;
      if (!a_stall) n++;
    end
    @(negedge clk);
    a_stb = 0; a_cyc = 0;
    sb_a.delete();
    #1;
    checks++;
    if (s_cyc !== 1'b0 || dut.u_ctr.count !== 5'd3) begin
      errors++;
      $display("FAIL abort_drop: got cyc=%b count=%0d, required 0 3", s_cyc, dut.u_ctr.count);
    end
    @(negedge clk);
    #1;
    checks++;
    if (dut.state !== ARB_IDLE || dut.u_ctr.count !== 5'd0) begin
      errors++;
      $display("FAIL abort_idle: got state=%0d count=%0d, required 0 0", dut.state, dut.u_ctr.count);
    end
    ack_en = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (a_ack !== 1'b0 || b_ack !== 1'b0) begin
        errors++;
        $display("FAIL abort_late_ack: got a_ack=%b b_ack=%b, required 0 0", a_ack, b_ack);
      end
    end
  endtask

  task automatic test_error();
    int n = 0;
    logic got = 0;
    err_en = 1; err_addr = AW'(32'h301);
    @(negedge clk);
    b_cyc = 1; b_stb = 1;
    for (int i = 0; i < 10 && n < 2; i++) begin
      @(negedge clk);
      b_addr = AW'(32'h300 + n);
      #1;
      if (!b_stall) n++;
    end
    @(negedge clk);
    b_stb = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (b_err) begin got = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (got !== 1'b1 || a_err !== 1'b0) begin
      errors++;
      $display("FAIL error_route: got b_err_seen=%b a_err=%b, required 1 0", got, a_err);
    end
    @(negedge clk);
    #1;
    checks++;
    if (dut.state !== ARB_IDLE || dut.u_ctr.count !== 5'd0) begin
      errors++;
      $display("FAIL error_idle: got state=%0d count=%0d, required 0 0", dut.state, dut.u_ctr.count);
    end
    b_cyc = 0;
    err_en = 0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int n = 0;
    ack_en = 0;
    @(negedge clk);
    a_cyc = 1; a_stb = 1;
    for (int i = 0; i < 10 && n < 2; i++) begin
      @(negedge clk);
      a_addr = AW'(32'h80 + n);
      #1;
      if (!a_stall) n++;
    end
    @(negedge clk);
    a_stb = 0;
    #3;
    rst = 1;
    #1;
    checks++;
    if (s_cyc !== 1'b0 || dut.state !== ARB_IDLE) begin
      errors++;
      $display("FAIL areset_drop: got cyc=%b state=%0d, required 0 0", s_cyc, dut.state);
    end
    sb_a.delete();
    a_cyc = 0;
    @(negedge clk);
    rst = 0;
    ack_en = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (a_ack !== 1'b0 || b_ack !== 1'b0) begin
        errors++;
        $display("FAIL areset_late_ack: got a_ack=%b b_ack=%b, required 0 0", a_ack, b_ack);
      end
    end
  endtask

`ifdef WBARB_FAIRNESS_EN
  task automatic test_fairness();
    int n = 0;
    logic saw_drain = 0, got_b = 0;
    do_reset();
    @(negedge clk);
    a_cyc = 1; a_stb = 1; a_we = 1; a_wdata = 32'h5a5a_0000;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      a_addr = AW'(32'h500 + n);
      #1;
      if (dut.state == ARB_OWN_A) b_cyc = 1;
      if (dut.state == ARB_DRAIN) saw_drain = 1;
      if (dut.state == ARB_OWN_B) begin got_b = 1; break; end
      if (!a_stall) n++;
    end
    checks++;
    if (n != MAXBURST || saw_drain !== 1'b1 || got_b !== 1'b1 || sb_a.size() != 0) begin
      errors++;
      $display("FAIL fair_handoff: got strobes=%0d drain=%b b_granted=%b pending=%0d, required 8 1 1 0", n, saw_drain, got_b, sb_a.size());
    end
    a_cyc = 0; a_stb = 0; a_we = 0; b_cyc = 0;
    @(negedge clk);
    @(negedge clk);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_a();
    test_tie();
    test_full();
    test_abort();
    test_error();
    test_async_reset();
`ifdef WBARB_FAIRNESS_EN
    test_fairness();
`endif
    repeat (3) @(negedge clk);
    #3;
    checks++;
    if (sb_a.size() != 0 || sb_b.size() != 0) begin
      errors++;
      $display("FAIL final_scoreboard: got a=%0d b=%0d outstanding, required 0 0", sb_a.size(), sb_b.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
